// File: rtl/pipeline_ctrl.sv
// Stall, flush and multi-cycle sequencing controller for the SimpleRisc 5-stage pipeline.
// Also keeps saturating stall and flush counters for performance debug.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | normal issue; decides multi start, branch flush, load-use
// MULTI  | div/mod holding EX; cnt counts the stall cycles left

module pipeline_ctrl #(
    parameter int MULTI_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_is_ld,
    input  logic             ex_is_multi,
    input  logic [3:0]       ex_rd,
    input  logic             is_branch_taken,
    input  logic             of_valid,
    input  logic [3:0]       of_rs1,
    input  logic [3:0]       of_rs2,
    input  logic             of_use_rs1,
    input  logic             of_use_rs2,
    input  logic             ctr_clr,
    output logic             stall_pc,
    output logic             stall_ifof,
    output logic             stall_ofex,
    output logic             bubble_ex,
    output logic             bubble_ma,
    output logic             flush,
    output logic             mdu_start,
    output logic             mdu_last,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_MULTI = 1'b1;

    // The first cycle of the op is spent in RUN, so MULTI covers the remaining MULTI_CYCLES-1.
    localparam logic [3:0] CNT_LOAD = (MULTI_CYCLES > 1) ? 4'(MULTI_CYCLES - 2) : 4'd0;
    localparam logic       MULTI_EN = (MULTI_CYCLES > 1);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0] state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic multi_req;
    logic multi_go;
    logic lu_hit;

    assign multi_req = ex_valid & ex_is_multi;
    assign multi_go  = multi_req & MULTI_EN;
    assign lu_hit    = ex_valid & ex_is_ld & of_valid &
                       ((of_use_rs1 & (of_rs1 == ex_rd)) |
                        (of_use_rs2 & (of_rs2 == ex_rd)));

    // Outputs are gated with rst_n so nothing leaks out while reset is held.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stall_pc   = 1'b0;
        stall_ifof = 1'b0;
        stall_ofex = 1'b0;
        bubble_ex  = 1'b0;
        bubble_ma  = 1'b0;
        flush      = 1'b0;
        mdu_start  = 1'b0;
        mdu_last   = 1'b0;

        if (rst_n) begin
            if (state == ST_MULTI) begin
                if (cnt != 4'd0) begin
                    stall_pc   = 1'b1;
                    stall_ifof = 1'b1;
                    stall_ofex = 1'b1;
                    bubble_ma  = 1'b1;
                    cnt_nxt    = cnt - 4'd1;
                end else begin
                    mdu_last  = 1'b1;
                    state_nxt = ST_RUN;
                end
            end else if (multi_go) begin
                mdu_start  = 1'b1;
                stall_pc   = 1'b1;
                stall_ifof = 1'b1;
                stall_ofex = 1'b1;
                bubble_ma  = 1'b1;
                cnt_nxt    = CNT_LOAD;
                state_nxt  = ST_MULTI;
            end else if (multi_req) begin
                mdu_start = 1'b1;
                mdu_last  = 1'b1;
            end else if (ex_valid & is_branch_taken) begin
                flush = 1'b1;
            end else if (lu_hit) begin
                stall_pc   = 1'b1;
                stall_ifof = 1'b1;
                bubble_ex  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign busy = (state == ST_MULTI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (ctr_clr) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_pc && (stall_cycles != CNT_MAX))
                stall_cycles <= stall_cycles + CNT_ONE;
            if (flush && (flush_count != CNT_MAX))
                flush_count <= flush_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomised and directed bench for pipeline_ctrl against an occupancy-based reference model.
// A second instance with 4-bit counters exercises counter saturation cheaply.

module tb_pipeline_ctrl;

    localparam int MC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ex_valid, ex_is_ld, ex_is_multi, is_branch_taken, of_valid;
    logic       of_use_rs1, of_use_rs2, ctr_clr;
    logic [3:0] ex_rd, of_rs1, of_rs2;

    logic        a_spc, a_sif, a_sox, a_bex, a_bma, a_fl, a_st, a_la, a_bz;
    logic        b_spc, b_sif, b_sox, b_bex, b_bma, b_fl, b_st, b_la, b_bz;
    logic [15:0] a_stall_cycles, a_flush_count;
    logic [3:0]  b_stall_cycles, b_flush_count;

    pipeline_ctrl #(.MULTI_CYCLES(MC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_ld(ex_is_ld),
        .ex_is_multi(ex_is_multi), .ex_rd(ex_rd), .is_branch_taken(is_branch_taken),
        .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2),
        .of_use_rs1(of_use_rs1), .of_use_rs2(of_use_rs2), .ctr_clr(ctr_clr),
        .stall_pc(a_spc), .stall_ifof(a_sif), .stall_ofex(a_sox), .bubble_ex(a_bex),
        .bubble_ma(a_bma), .flush(a_fl), .mdu_start(a_st), .mdu_last(a_la), .busy(a_bz),
        .stall_cycles(a_stall_cycles), .flush_count(a_flush_count)
    );

    pipeline_ctrl #(.MULTI_CYCLES(MC), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_ld(ex_is_ld),
        .ex_is_multi(ex_is_multi), .ex_rd(ex_rd), .is_branch_taken(is_branch_taken),
        .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2),
        .of_use_rs1(of_use_rs1), .of_use_rs2(of_use_rs2), .ctr_clr(ctr_clr),
        .stall_pc(b_spc), .stall_ifof(b_sif), .stall_ofex(b_sox), .bubble_ex(b_bex),
        .bubble_ma(b_bma), .flush(b_fl), .mdu_start(b_st), .mdu_last(b_la), .busy(b_bz),
        .stall_cycles(b_stall_cycles), .flush_count(b_flush_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int occ_left = 0;     // cycles the current multi op still occupies EX after this one
    int stall_n  = 0;
    int flush_n  = 0;
    int cyc      = 0;
    int last_start = -100;
    int gap      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    // Order: {stall_pc, stall_ifof, stall_ofex, bubble_ex, bubble_ma, flush, mdu_start, mdu_last, busy}
    function automatic logic [8:0] model_out();
        logic hold, bex, bma, fl, st, la, bz, lu, spc, sif, sox;
        {spc, sif, sox, bex, bma, fl, st, la, bz} = '0;
        hold = 1'b0;
        if (!rst_n) return 9'b0;
        lu = ex_valid && ex_is_ld && of_valid &&
             ((of_use_rs1 && of_rs1 == ex_rd) || (of_use_rs2 && of_rs2 == ex_rd));
        if (occ_left > 0) begin
            bz = 1'b1;
            if (occ_left == 1) la = 1'b1;
            else hold = 1'b1;
        end else if (ex_valid && ex_is_multi) begin
            st = 1'b1;
            if (MC == 1) la = 1'b1;
            else hold = 1'b1;
        end else if (ex_valid && is_branch_taken) begin
            fl = 1'b1;
        end else if (lu) begin
            spc = 1'b1; sif = 1'b1; bex = 1'b1;
        end
        if (hold) begin
            spc = 1'b1; sif = 1'b1; sox = 1'b1; bma = 1'b1;
        end
        return {spc, sif, sox, bex, bma, fl, st, la, bz};
    endfunction

    task automatic set_in(input logic ev, input logic ld, input logic mu, input logic [3:0] rd,
                          input logic br, input logic ov, input logic [3:0] r1, input logic [3:0] r2,
                          input logic u1, input logic u2, input logic clr);
        ex_valid = ev; ex_is_ld = ld; ex_is_multi = mu; ex_rd = rd; is_branch_taken = br;
        of_valid = ov; of_rs1 = r1; of_rs2 = r2; of_use_rs1 = u1; of_use_rs2 = u2; ctr_clr = clr;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic cycle();
        logic [8:0] e;
        #1;
        e = model_out();
        check("ctrl", {23'd0, a_spc, a_sif, a_sox, a_bex, a_bma, a_fl, a_st, a_la, a_bz}, {23'd0, e});
        check("ctrl_small", {23'd0, b_spc, b_sif, b_sox, b_bex, b_bma, b_fl, b_st, b_la, b_bz}, {23'd0, e});
        check("stall_cycles", {16'd0, a_stall_cycles}, sat(stall_n, 16));
        check("flush_count", {16'd0, a_flush_count}, sat(flush_n, 16));
        check("stall_cycles_sat", {28'd0, b_stall_cycles}, sat(stall_n, 4));
        check("flush_count_sat", {28'd0, b_flush_count}, sat(flush_n, 4));
        if (a_st) begin
            gap = cyc - last_start;
            last_start = cyc;
        end
        @(posedge clk);
        if (rst_n) begin
            if (ctr_clr) begin
                stall_n = 0;
                flush_n = 0;
            end else begin
                stall_n += int'(e[8]);
                flush_n += int'(e[3]);
            end
            if (occ_left > 0) occ_left--;
            else if (e[2] && MC > 1) occ_left = MC - 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic rand_in();
        set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
               4'($urandom_range(0, 3)), $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
    endtask

    initial begin
        // Reset held with inputs that would otherwise start a div.
        set_in(1'b1, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0);
        cycle();
        cycle();
        rst_n = 1'b1;
        idle();
        cycle();

        // Single div: stalls in 3 cycles, mdu_last in the 4th.
        idle(); ctr_clr = 1'b1;
        cycle();
        for (int i = 0; i < MC; i++) begin
            set_in(1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0);
            cycle();
        end
        idle();
        cycle();
        check("div_stalls", {16'd0, a_stall_cycles}, 32'd3);

        // Load to r5, OF reads r5 via rs2.
        set_in(1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 4'd0, 4'd5, 1'b0, 1'b1, 1'b0);
        #1 check("lu_hit", {28'd0, a_spc, a_sif, a_bex, a_sox}, 32'b1110);
        cycle();
        set_in(1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0);
        #1 check("lu_no_use", {31'd0, a_spc}, 32'd0);
        cycle();
        set_in(1'b1, 1'b1, 1'b0, 4'd6, 1'b0, 1'b1, 4'd0, 4'd5, 1'b0, 1'b1, 1'b0);
        #1 check("lu_other_rd", {31'd0, a_spc}, 32'd0);
        cycle();

        // Branch taken with a load-use match present: flush wins.
        idle(); ctr_clr = 1'b1;
        cycle();
        set_in(1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0);
        #1 check("br_flush", {30'd0, a_fl, a_spc}, 32'b10);
        cycle();
        idle();
        cycle();
        check("br_flush_count", {16'd0, a_flush_count}, 32'd1);

        // Back-to-back divs.
        for (int i = 0; i < 2 * MC; i++) begin
            set_in(1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 4'd7, 4'd7, 1'b1, 1'b1, 1'b0);
            cycle();
        end
        check("start_gap", gap, MC);
        idle();
        cycle();

        // Reset during MULTI cycle 1.
        set_in(1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 4'd2, 4'd2, 1'b1, 1'b1, 1'b0);
        cycle();
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {23'd0, a_spc, a_sif, a_sox, a_bex, a_bma, a_fl, a_st, a_la, a_bz}, 32'd0);
        check("rst_mid_cnt", {a_stall_cycles, a_flush_count}, 32'd0);
        occ_left = 0; stall_n = 0; flush_n = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        cycle();
        check("rst_mid_busy", {31'd0, a_bz}, 32'd0);

        // Saturation on the 4-bit instance, then clear beating a stall.
        idle(); ctr_clr = 1'b1;
        cycle();
        for (int i = 0; i < 17; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 4'd9, 4'd0, 1'b1, 1'b0, 1'b0);
            cycle();
        end
        check("sat_hold", {28'd0, b_stall_cycles}, 32'hF);
        set_in(1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 4'd9, 4'd0, 1'b1, 1'b0, 1'b1);
        cycle();
        idle();
        cycle();
        check("clr_wins", {16'd0, a_stall_cycles}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            rand_in();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Stall/flush/sequencing controller for the 5-stage SimpleRisc pipeline. It sits beside the execution stage and watches the instruction in EX and the one in OF. It generates load-use interlock bubbles, branch flushes, and multi-cycle hold sequencing for div/mod operations in the EX ALU. It also keeps saturating stall and flush counters for performance debug.

## Interface
- MULTI_CYCLES, 4: total cycles a div/mod instruction occupies EX (legal range 1..16).
- CNT_W, 16: width of the performance counters.

- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction.
- ex_is_ld  in  1  EX instruction is a load.
- ex_is_multi  in  1  EX instruction is div or mod (multi-cycle ALU op).
- ex_rd  in  4  destination register of EX instruction.
- is_branch_taken  in  1  branch resolution from the execution unit.
- of_valid  in  1  OF stage holds a real instruction.
- of_rs1, of_rs2  in  4 each  OF source registers.
- of_use_rs1, of_use_rs2  in  1 each  OF instruction actually reads that source.
- ctr_clr  in  1  synchronous clear of both counters.
- stall_pc  out  1  hold PC.
- stall_ifof  out  1  hold IF/OF latch.
- stall_ofex  out  1  hold OF/EX latch.
- bubble_ex  out  1  load NOP into OF/EX latch.
- bubble_ma  out  1  load NOP into EX/MA latch.
- flush  out  1  kill IF/OF and OF/EX contents (load NOPs).
- mdu_start  out  1  one-cycle pulse: start the div/mod operation.
- mdu_last  out  1  final EX cycle of a multi-cycle op; EX/MA captures the result.
- busy  out  1  state is MULTI.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_pc=1.
- flush_count  out  CNT_W  saturating count of flush pulses.

## Operation
- States: RUN (0), MULTI (1). Down-counter cnt is 4 bits.
- Define the internal signals:
  - multi_go = ex_valid & ex_is_multi & MULTI_CYCLES>1.
  - lu_hit = ex_valid & ex_is_ld & of_valid & ((of_use_rs1 & of_rs1==ex_rd) | (of_use_rs2 & of_rs2==ex_rd)).
- Outputs are evaluated in priority order, highest first.
- Priority 1, state MULTI:
  - If cnt≠0: assert stall_pc, stall_ifof, stall_ofex and bubble_ma; decrement cnt.
  - If cnt==0: assert mdu_last with all stalls low, and go to RUN.
- Priority 2, RUN with multi_go:
  - Assert mdu_start, stall_pc, stall_ifof, stall_ofex and bubble_ma.
  - Load cnt=MULTI_CYCLES-2 and go to MULTI.
- RUN with ex_valid & ex_is_multi and MULTI_CYCLES==1: assert mdu_start and mdu_last in the same cycle, with no stall.
- Priority 3, RUN with ex_valid & is_branch_taken: assert flush for one cycle. Stalls are low.
- Priority 4, RUN with lu_hit: assert stall_pc, stall_ifof and bubble_ex for exactly one cycle. No state change is needed because the load moves to MA next cycle.
- is_branch_taken together with ex_is_multi is illegal. multi wins and flush is suppressed.
- stall_cycles:
  - Increments each cycle stall_pc=1.
  - Saturates at all-ones.
  - ctr_clr has priority over increment.
- flush_count follows the same rules as stall_cycles, incrementing on flush=1.
- Reset:
  - state=RUN, cnt=0, both counters=0.
  - All outputs are forced to 0 while rst_n=0, even if inputs would assert them.
- Reset asserted mid-MULTI: the machine aborts immediately and the holds drop. No mdu_last is issued.

## Timing
- All outputs except counters, busy and state are combinational from inputs and registered state, valid in the same cycle.
- A multi-cycle op occupies EX for exactly MULTI_CYCLES cycles. Stalls are asserted in the first MULTI_CYCLES-1 of them. mdu_start is in cycle 1 and mdu_last is in cycle MULTI_CYCLES.
- Load-use costs exactly 1 bubble. Branch costs 2 killed instructions in a single flush cycle.
- busy=1 from the cycle after mdu_start through the mdu_last cycle inclusive.
- Counter outputs are registered: they update on the edge after the counted event.
- ex_is_multi inputs must be ignored while in MULTI. The held instruction is not re-triggered on mdu_last.

## Test plan
- MULTI_CYCLES=4, issue div in EX:
  - mdu_start in cycle 0, stalls and bubble_ma in cycles 0-2, mdu_last in cycle 3.
  - busy is set in cycles 1-3.
  - stall_cycles=3 after the sequence.
- Load to r5 in EX, OF reads r5 via rs2 with of_use_rs2=1:
  - One cycle of stall_pc, stall_ifof and bubble_ex.
  - Repeat with of_use_rs2=0 or rd=r6: no stall.
- Branch taken in EX with OF holding a load-use match: flush=1, no stall, flush_count=1.
- Back-to-back div instructions: the second starts on the cycle after the first's mdu_last, with a 4-cycle spacing between mdu_start pulses.
- Assert rst_n=0 during MULTI cycle 1:
  - All outputs go to 0 immediately.
  - After release, state is RUN and counters are 0.
- Force stall_cycles to 0xFFFE, then stall 3 cycles: it holds at 0xFFFF. ctr_clr together with a stall gives 0.
